// File: rtl/object_buffer_arb.sv
// object_buffer_arb: round-robin arbiter that locks the object_buffer write
// port to one producer for a whole message (run of entries ending in last).
// Optional lock watchdog enabled by defining OBJ_BUFFER_ARB_TIMEOUT_EN.
module object_buffer_arb #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned ENTRY_W = 128,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [NUM_REQ-1:0]           req_valid,
  input  logic [NUM_REQ-1:0]           req_last,
  input  logic [NUM_REQ*ENTRY_W-1:0]   req_entry,
  output logic [NUM_REQ-1:0]           req_ready,
  output logic [ENTRY_W-1:0]           new_entry,
  output logic                         valid_in,
  input  logic                         full,
  output logic [$clog2(NUM_REQ)-1:0]   owner,
  output logic                         busy,
  output logic [15:0]                  entry_count,
  output logic                         timeout_err
);

  localparam int unsigned OW = $clog2(NUM_REQ);

  typedef enum logic {IDLE, LOCK} state_t;

  state_t          state;
  logic [OW-1:0]   last_owner;
  logic [OW-1:0]   grant_idx;
  logic            grant_any;
  logic [OW-1:0]   cand;
  logic            xfer;

  // Circular priority search starting just after the previous owner
  always_comb begin
    grant_idx = '0;
    grant_any = 1'b0;
    cand      = '0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      cand = OW'((32'(last_owner) + k) % NUM_REQ);
      if (!grant_any && req_valid[cand]) begin
        grant_idx = cand;
        grant_any = 1'b1;
      end
    end
  end

  // Combinational handshake into object_buffer while locked
  always_comb begin
    xfer      = (state == LOCK) & req_valid[owner] & ~full;
    valid_in  = xfer;
    busy      = (state == LOCK);
    new_entry = '0;
    req_ready = '0;
    if (state == LOCK) begin
      new_entry = req_entry[32'(owner)*ENTRY_W +: ENTRY_W];
    end
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      req_ready[i] = (state == LOCK) & (owner == OW'(i)) & ~full;
    end
  end

`ifdef OBJ_BUFFER_ARB_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] stall_cnt;
`else
  logic unused_timeout;
  assign unused_timeout = ^32'(TIMEOUT);
  assign timeout_err    = 1'b0;
`endif

  // Lock FSM, owner tracking and entry counter
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      owner       <= '0;
      last_owner  <= OW'(NUM_REQ - 1);
      entry_count <= '0;
`ifdef OBJ_BUFFER_ARB_TIMEOUT_EN
      stall_cnt   <= '0;
      timeout_err <= 1'b0;
`endif
    end else begin
      if (xfer && entry_count != 16'hFFFF) begin
        entry_count <= entry_count + 16'd1;
      end
      case (state)
        IDLE: begin
          if (grant_any) begin
            owner      <= grant_idx;
            last_owner <= grant_idx;
            state      <= LOCK;
`ifdef OBJ_BUFFER_ARB_TIMEOUT_EN
            stall_cnt  <= '0;
`endif
          end
        end
        LOCK: begin
          if (xfer && req_last[owner]) begin
            state <= IDLE;
          end
`ifdef OBJ_BUFFER_ARB_TIMEOUT_EN
          // Idle owner with room available: count toward the watchdog
          if (xfer) begin
            stall_cnt <= '0;
          end else if (!full && !req_valid[owner]) begin
            if (stall_cnt == TW'(TIMEOUT - 1)) begin
              state       <= IDLE;
              timeout_err <= 1'b1;
              stall_cnt   <= '0;
            end else begin
              stall_cnt <= stall_cnt + TW'(1);
            end
          end
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_object_buffer_arb.sv
// Directed testbench for object_buffer_arb (NUM_REQ=4, ENTRY_W=128).
module tb_object_buffer_arb;

  localparam int unsigned NR = 4;
  localparam int unsigned EW = 128;
`ifdef OBJ_BUFFER_ARB_TIMEOUT_EN
  localparam int unsigned TO = 8;
`else
  localparam int unsigned TO = 64;
`endif

  logic              clk;
  logic              reset;
  logic [NR-1:0]     req_valid;
  logic [NR-1:0]     req_last;
  logic [NR*EW-1:0]  req_entry;
  logic [NR-1:0]     req_ready;
  logic [EW-1:0]     new_entry;
  logic              valid_in;
  logic              full;
  logic [1:0]        owner;
  logic              busy;
  logic [15:0]       entry_count;
  logic              timeout_err;

  int checks = 0;
  int errors = 0;

  object_buffer_arb #(.NUM_REQ(NR), .ENTRY_W(EW), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_last(req_last), .req_entry(req_entry),
    .req_ready(req_ready), .new_entry(new_entry), .valid_in(valid_in),
    .full(full), .owner(owner), .busy(busy),
    .entry_count(entry_count), .timeout_err(timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic set_entry(input int i, input logic [127:0] v);
    req_entry[i*EW +: EW] = v;
  endtask

  initial begin
    reset     = 1'b0;
    req_valid = '0;
    req_last  = '0;
    req_entry = '0;
    full      = 1'b0;

    // Reset held for two cycles
    step();
    step();
    check("rst_valid_in", 128'(valid_in), 128'd0);
    check("rst_busy", 128'(busy), 128'd0);
    reset = 1'b1;
    step();
    check("idle_valid_in", 128'(valid_in), 128'd0);
    check("idle_busy", 128'(busy), 128'd0);
    check("idle_owner", 128'(owner), 128'd0);
    check("idle_count", 128'(entry_count), 128'd0);
    check("idle_ready", 128'(req_ready), 128'd0);
    check("idle_terr", 128'(timeout_err), 128'd0);

    // Single 3-entry message from requester 1
    set_entry(1, 128'hA1);
    req_valid = 4'b0010;
    settle();
    check("msg_bubble_busy", 128'(busy), 128'd0);
    check("msg_bubble_vin", 128'(valid_in), 128'd0);
    step();
    check("msg_busy", 128'(busy), 128'd1);
    check("msg_owner", 128'(owner), 128'd1);
    check("msg_ready", 128'(req_ready), 128'b0010);
    check("msg_vin0", 128'(valid_in), 128'd1);
    check("msg_e0", new_entry, 128'hA1);
    step();
    set_entry(1, 128'hA2);
    settle();
    check("msg_vin1", 128'(valid_in), 128'd1);
    check("msg_e1", new_entry, 128'hA2);
    check("msg_cnt1", 128'(entry_count), 128'd1);
    step();
    set_entry(1, 128'hA3);
    req_last = 4'b0010;
    settle();
    check("msg_vin2", 128'(valid_in), 128'd1);
    check("msg_e2", new_entry, 128'hA3);
    step();
    req_valid = '0;
    req_last  = '0;
    settle();
    check("msg_done_busy", 128'(busy), 128'd0);
    check("msg_done_vin", 128'(valid_in), 128'd0);
    check("msg_done_entry", new_entry, 128'd0);
    check("msg_cnt3", 128'(entry_count), 128'd3);

    // Round robin after a fresh reset: 0, 2, 3 all pending
    reset = 1'b0;
    step();
    reset = 1'b1;
    set_entry(0, 128'hB0);
    set_entry(2, 128'hB2);
    set_entry(3, 128'hB3);
    req_valid = 4'b1101;
    req_last  = 4'b1101;
    step();
    check("rr_owner0", 128'(owner), 128'd0);
    check("rr_entry0", new_entry, 128'hB0);
    check("rr_ready0", 128'(req_ready), 128'b0001);
    step();
    req_valid = 4'b1100;
    settle();
    check("rr_bubble1", 128'(busy), 128'd0);
    check("rr_bubble1_rdy", 128'(req_ready), 128'd0);
    step();
    check("rr_owner2", 128'(owner), 128'd2);
    check("rr_entry2", new_entry, 128'hB2);
    check("rr_ready2", 128'(req_ready), 128'b0100);
    step();
    req_valid = 4'b1000;
    settle();
    check("rr_bubble2", 128'(busy), 128'd0);
    step();
    check("rr_owner3", 128'(owner), 128'd3);
    check("rr_entry3", new_entry, 128'hB3);
    step();
    req_valid = '0;
    req_last  = '0;
    settle();
    check("rr_cnt", 128'(entry_count), 128'd3);

    // Back-pressure mid-message from requester 0
    set_entry(0, 128'hC0);
    req_valid = 4'b0001;
    step();
    check("bp_owner", 128'(owner), 128'd0);
    check("bp_vin0", 128'(valid_in), 128'd1);
    step();
    set_entry(0, 128'hC1);
    full = 1'b1;
    settle();
    for (int c = 0; c < 4; c++) begin
      check("bp_full_vin", 128'(valid_in), 128'd0);
      check("bp_full_rdy", 128'(req_ready), 128'd0);
      check("bp_full_cnt", 128'(entry_count), 128'd4);
      check("bp_full_busy", 128'(busy), 128'd1);
      step();
    end
    full = 1'b0;
    settle();
    check("bp_resume_vin", 128'(valid_in), 128'd1);
    check("bp_resume_e", new_entry, 128'hC1);
    check("bp_resume_cnt", 128'(entry_count), 128'd4);
    step();
    set_entry(0, 128'hC2);
    req_last = 4'b0001;
    settle();
    check("bp_e2", new_entry, 128'hC2);
    check("bp_cnt5", 128'(entry_count), 128'd5);
    step();
    req_valid = '0;
    req_last  = '0;
    settle();
    check("bp_cnt6", 128'(entry_count), 128'd6);
    check("bp_idle", 128'(busy), 128'd0);

    // Lock hold: requester 2 stalls while requester 0 waits
    set_entry(0, 128'hD0);
    set_entry(2, 128'hD2);
    req_valid = 4'b0101;
    step();
    check("lh_owner", 128'(owner), 128'd2);
    step();
    req_valid = 4'b0001;
    settle();
    for (int c = 0; c < 5; c++) begin
      check("lh_owner_hold", 128'(owner), 128'd2);
      check("lh_busy", 128'(busy), 128'd1);
      check("lh_rdy0", 128'(req_ready[0]), 128'd0);
      check("lh_vin", 128'(valid_in), 128'd0);
      step();
    end
    set_entry(2, 128'hD3);
    req_valid = 4'b0101;
    req_last  = 4'b0101;
    settle();
    check("lh_resume_e", new_entry, 128'hD3);
    check("lh_cnt", 128'(entry_count), 128'd7);
    step();
    req_valid = 4'b0001;
    step();
    check("lh_next_owner", 128'(owner), 128'd0);
    check("lh_next_e", new_entry, 128'hD0);
    step();
    req_valid = '0;
    req_last  = '0;
    settle();
    check("lh_cnt9", 128'(entry_count), 128'd9);
    check("lh_terr", 128'(timeout_err), 128'd0);

`ifdef OBJ_BUFFER_ARB_TIMEOUT_EN
    // Watchdog: requester 1 stalls with room available
    req_valid = 4'b0010;
    step();
    check("to_owner", 128'(owner), 128'd1);
    req_valid = '0;
    for (int c = 0; c < 7; c++) step();
    check("to_still_busy", 128'(busy), 128'd1);
    step();
    check("to_idle", 128'(busy), 128'd0);
    check("to_err", 128'(timeout_err), 128'd1);
    // Same stall with full high never times out
    reset = 1'b0;
    step();
    reset = 1'b1;
    req_valid = 4'b0001;
    step();
    req_valid = '0;
    full = 1'b1;
    for (int c = 0; c < 12; c++) step();
    check("to_full_busy", 128'(busy), 128'd1);
    check("to_full_err", 128'(timeout_err), 128'd0);
    full = 1'b0;
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/object_buffer_arb.md
# object_buffer_arb

Round-robin arbiter and sequencer that shares the single write port of `object_buffer` between `NUM_REQ` producers, such as the field decoder and nested-message unit. Each producer pushes a multi-entry message (a run of 128-bit `TABLE_ENTRY` words terminated by `last`). The arbiter locks the port to one producer for the whole message, so entries of different messages never interleave. It drives `new_entry`/`valid_in` directly into `object_buffer` and honours its `full`.

## Interface
- `NUM_REQ`, 4: number of requesters (2..8).
- `ENTRY_W`, 128: entry width; equals `$bits(TABLE_ENTRY)`.
- `TIMEOUT`, 64: lock-watchdog limit in cycles; used only with the macro.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `req_valid`  in  NUM_REQ  per-requester entry valid.
- `req_last`  in  NUM_REQ  per-requester: the current entry is the last of its message.
- `req_entry`  in  NUM_REQ*ENTRY_W  per-requester entry; requester i occupies bits [i*ENTRY_W +: ENTRY_W].
- `req_ready`  out  NUM_REQ  per-requester accept.
- `new_entry`  out  ENTRY_W  entry to `object_buffer`.
- `valid_in`  out  1  write strobe to `object_buffer`.
- `full`  in  1  `object_buffer` full status.
- `owner`  out  $clog2(NUM_REQ)  index of the locked requester.
- `busy`  out  1  high while in LOCK.
- `entry_count`  out  16  saturating count of entries written.
- `timeout_err`  out  1  sticky watchdog flag.

## Operation
- FSM states: IDLE, LOCK.
- **IDLE:**
  - If any `req_valid` bit is high, pick the first set bit, searching circularly from `last_owner+1`.
  - Register the winner into `owner` and `last_owner`, then go to LOCK.
  - If no bit is high, stay in IDLE.
  - No transfer happens in IDLE, so every message costs one arbitration bubble.
- **LOCK:**
  - `xfer = req_valid[owner] & ~full`.
  - `req_ready[i] = LOCK & (i==owner) & ~full`.
  - `valid_in = xfer`.
  - `new_entry = req_entry[owner]` while in LOCK, otherwise 0.
  - On `xfer & req_last[owner]`: go to IDLE.
  - Otherwise stay in LOCK, including when `req_valid[owner]` drops mid-message; the lock holds until `last`.
- **Ready on `full`:** `full` high blocks every `req_ready`. Requesters must hold `req_entry`/`req_last` stable while valid and not ready.
- **Requesters not owning the lock:** `req_ready` stays 0 and they keep waiting. Fairness comes from the rotating start point. A lone requester is re-granted after its one-cycle bubble.
- **`entry_count`:** increments by 1 on every `xfer` and saturates at 16'hFFFF.
- **`busy`:** equals (state == LOCK).

## Timing
- Datapath is combinational from `req_*` and `full` to `valid_in`/`new_entry`/`req_ready`. `object_buffer` captures the entry on the same rising edge that completes the handshake.
- Grant latency: a request seen in IDLE at edge N is in LOCK after edge N; its first transfer can complete at edge N+1.
- Peak throughput: one entry per cycle inside a message.
- Reset values (asserted immediately while `reset`=0):
  - state IDLE
  - `owner`=0
  - `last_owner`=NUM_REQ-1, so requester 0 wins the first arbitration
  - `entry_count`=0
  - `timeout_err`=0
  - `valid_in`=0, `req_ready`=0, `new_entry`=0, `busy`=0
- Reset during LOCK abandons the message. `valid_in` falls asynchronously with the state.
- `full` and `req_valid` both changing in one cycle: only the current-cycle values matter, since there is no registered datapath.

## Configuration
- Macro: `OBJ_BUFFER_ARB_TIMEOUT_EN`.
- **Defined:**
  - A counter tracks consecutive LOCK cycles in which `full`=0 and `req_valid[owner]`=0. It clears on any `xfer` and on entry to LOCK.
  - When the counter reaches `TIMEOUT`, the FSM forces IDLE and sets `timeout_err`.
  - `timeout_err` stays high until reset.
  - Cycles with `full`=1 never count toward the timeout.
- **Not defined:** no counter; the lock is held indefinitely; `timeout_err` is tied to 0.

## Test plan
- **Reset:** hold `reset`=0 for 2 cycles, then release with no requests -> `valid_in`=0, `busy`=0, `owner`=0, `entry_count`=0.
- **Single message:** requester 1 sends 3 entries (last on the 3rd), `full`=0 -> `busy` rises 1 cycle after `req_valid`; `valid_in` is high for 3 consecutive cycles with entries in order; then IDLE; `entry_count`=3.
- **Round robin:** requesters 0, 2 and 3 each send a 1-entry message, all valid simultaneously after reset -> grant order 0, 2, 3 with one IDLE bubble between grants.
- **Back-pressure:** `full`=1 for 4 cycles mid-message from requester 0 -> `req_ready`=0 and `valid_in`=0 while full; no entry lost or duplicated; `entry_count` unchanged until `full` drops.
- **Lock hold:** requester 2 drops `req_valid` for 5 cycles before `last` while requester 0 is waiting -> `owner` stays 2 and requester 0 `req_ready` stays 0.
- **Timeout (macro defined, `TIMEOUT`=8):** requester 1 stalls for 8 cycles with `full`=0 -> FSM returns to IDLE on the 8th cycle and `timeout_err`=1 until reset. The same stall with `full`=1 -> no timeout.
